// File: rtl/lstm_sa_datapath_if.sv
// Handshake and data bus between the LSTM cell/weight fetcher side and the systolic datapath.
interface lstm_sa_datapath_if #(
  parameter int unsigned FEATURE_BITS = 4,
  parameter int unsigned ELEMENT_BITS = 8,
  parameter int unsigned P            = 4
);
  logic                      start_load_hidden;
  logic [FEATURE_BITS-1:0]   hidden_address;
  logic [ELEMENT_BITS-1:0]   lc_data_in;
  logic                      start_load_input;
  logic [ELEMENT_BITS-1:0]   mmi_data;
  logic                      done_load_input;
  logic                      start_operate;
  logic                      weight_req;
  logic [P*ELEMENT_BITS-1:0] weight_data;
  logic [ELEMENT_BITS-1:0]   lc_data_out;
  logic                      lc_oe_out;
  logic                      done_operate;

  modport master (
    output start_load_hidden, hidden_address, lc_data_in, start_load_input,
           mmi_data, start_operate, weight_data,
    input  done_load_input, weight_req, lc_data_out, lc_oe_out, done_operate
  );

  modport slave (
    input  start_load_hidden, hidden_address, lc_data_in, start_load_input,
           mmi_data, start_operate, weight_data,
    output done_load_input, weight_req, lc_data_out, lc_oe_out, done_operate
  );
endinterface

// File: rtl/lstm_sa_datapath.sv
// LSTM systolic-array datapath: x staging buffer, P-PE MAC array, drain/saturate and
// result stream to the cell. Computes y = W*x over GAMMA passes of P rows each.
module lstm_sa_datapath #(
  parameter int unsigned FEATURE_BITS = 4,
  parameter int unsigned ELEMENT_BITS = 8,
  parameter int unsigned P            = 4,
  parameter int unsigned M            = 9,
  parameter int unsigned FEATURES     = 4,
  parameter int unsigned FRAC_BITS    = 4
) (
  input logic              sys_clk,
  input logic              reset_n,
  lstm_sa_datapath_if.slave bus
);
  localparam int unsigned K     = FEATURES + M;
  localparam int unsigned GAMMA = (M + P - 1) / P;
  localparam int unsigned ACC_W = 2 * ELEMENT_BITS + FEATURE_BITS;
  localparam int unsigned FB    = FEATURE_BITS;
  localparam int unsigned EB    = ELEMENT_BITS;
  localparam int unsigned RW    = $clog2(GAMMA * P + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (EB - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (EB - 1)));

  typedef enum logic [2:0] {IDLE, LOAD_IN, COMPUTE, DRAIN, STREAM} state_t;

  state_t                   r_state;
  logic [FB-1:0]            r_cnt;
  logic [FB-1:0]            r_k;
  logic [FB-1:0]            r_j;
  logic [RW-1:0]            r_g;
  logic [RW-1:0]            r_d;
  logic signed [EB-1:0]     r_x    [K];
  logic signed [ACC_W-1:0]  r_acc  [P];
  logic [EB-1:0]            r_ybuf [M];
  logic                     r_done_load;
  logic                     r_weight_req;
  logic [EB-1:0]            r_dout;
  logic                     r_oe;
  logic                     r_done_op;

  logic signed [EB-1:0]     w_w    [P];
  logic signed [ACC_W-1:0]  w_prod [P];
  logic signed [EB-1:0]     w_xk;
  logic signed [ACC_W-1:0]  w_shift;
  logic [EB-1:0]            w_sat;
  logic [RW-1:0]            w_row;
  logic [FB-1:0]            w_hid_idx;
  logic                     w_hid_we;

  // Broadcast x[k] against each PE's weight slice; drain side rounds acc_0 into a y element.
  always_comb begin
    w_xk = r_x[r_k];
    for (int i = 0; i < P; i++) begin
      w_w[i]    = bus.weight_data[i*EB +: EB];
      w_prod[i] = ACC_W'(w_w[i]) * ACC_W'(w_xk);
    end
    w_shift = r_acc[0] >>> FRAC_BITS;
    if (w_shift > SAT_MAX)      w_sat = SAT_MAX[EB-1:0];
    else if (w_shift < SAT_MIN) w_sat = SAT_MIN[EB-1:0];
    else                        w_sat = w_shift[EB-1:0];
    w_row     = r_g * RW'(P) + r_d;
    w_hid_idx = FB'(FEATURES) + bus.hidden_address;
    w_hid_we  = bus.start_load_hidden && (bus.hidden_address < FB'(M)) &&
                (r_state != COMPUTE) && (r_state != DRAIN);
  end

  // Control FSM; outputs are registered for the state being entered.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_k          <= '0;
      r_j          <= '0;
      r_g          <= '0;
      r_d          <= '0;
      r_done_load  <= 1'b0;
      r_weight_req <= 1'b0;
      r_dout       <= '0;
      r_oe         <= 1'b0;
      r_done_op    <= 1'b0;
      for (int i = 0; i < K; i++) r_x[i]    <= '0;
      for (int i = 0; i < P; i++) r_acc[i]  <= '0;
      for (int i = 0; i < M; i++) r_ybuf[i] <= '0;
    end else begin
      r_done_load  <= 1'b0;
      r_weight_req <= 1'b0;
      r_dout       <= '0;
      r_oe         <= 1'b0;
      r_done_op    <= 1'b0;
      if (w_hid_we) r_x[w_hid_idx] <= bus.lc_data_in;
      case (r_state)
        IDLE: begin
          if (bus.start_load_input) begin
            r_state <= LOAD_IN;
            r_cnt   <= '0;
          end else if (bus.start_operate) begin
            r_state      <= COMPUTE;
            r_g          <= '0;
            r_k          <= '0;
            r_weight_req <= 1'b1;
          end
        end
        LOAD_IN: begin
          r_x[r_cnt] <= bus.mmi_data;
          if (r_cnt == FB'(FEATURES - 1)) begin
            r_state     <= IDLE;
            r_done_load <= 1'b1;
          end else begin
            r_cnt <= r_cnt + FB'(1);
          end
        end
        COMPUTE: begin
          for (int i = 0; i < P; i++) begin
            if (r_k == '0) r_acc[i] <= w_prod[i];
            else           r_acc[i] <= r_acc[i] + w_prod[i];
          end
          if (r_k == FB'(K - 1)) begin
            r_state <= DRAIN;
            r_d     <= '0;
          end else begin
            r_k          <= r_k + FB'(1);
            r_weight_req <= 1'b1;
          end
        end
        DRAIN: begin
          // PE chain shifts toward PE0; padding rows of the last pass are dropped.
          if (w_row < RW'(M)) r_ybuf[w_row] <= w_sat;
          for (int i = 0; i < P - 1; i++) r_acc[i] <= r_acc[i+1];
          r_acc[P-1] <= '0;
          if (r_d == RW'(P - 1)) begin
            if (r_g == RW'(GAMMA - 1)) begin
              r_state <= STREAM;
              r_j     <= '0;
              r_oe    <= 1'b1;
              r_dout  <= r_ybuf[0];
            end else begin
              r_state      <= COMPUTE;
              r_g          <= r_g + RW'(1);
              r_k          <= '0;
              r_weight_req <= 1'b1;
            end
          end else begin
            r_d <= r_d + RW'(1);
          end
        end
        STREAM: begin
          if (r_j == FB'(M - 1)) begin
            r_state   <= IDLE;
            r_done_op <= 1'b1;
          end else begin
            r_j    <= r_j + FB'(1);
            r_oe   <= 1'b1;
            r_dout <= r_ybuf[r_j + FB'(1)];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.done_load_input = r_done_load;
  assign bus.weight_req      = r_weight_req;
  assign bus.lc_data_out     = r_dout;
  assign bus.lc_oe_out       = r_oe;
  assign bus.done_operate    = r_done_op;
endmodule

// File: tb/tb_lstm_sa_datapath.sv
// Directed bench for lstm_sa_datapath: load, product, saturation, guards and mid-op reset.
module tb_lstm_sa_datapath;
  logic sys_clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  lstm_sa_datapath_if #(.FEATURE_BITS(4), .ELEMENT_BITS(8), .P(4)) bus ();

  lstm_sa_datapath #(
    .FEATURE_BITS(4), .ELEMENT_BITS(8), .P(4), .M(9), .FEATURES(4), .FRAC_BITS(4)
  ) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_hidden(input logic [3:0] addr, input logic [7:0] val);
    bus.start_load_hidden = 1'b1;
    bus.hidden_address    = addr;
    bus.lc_data_in        = val;
    step();
    bus.start_load_hidden = 1'b0;
  endtask

  // Start pulse, then FEATURES samples; done pulse expected on the 5th cycle.
  task automatic load_inputs(input string tag, input logic [7:0] v0, input logic [7:0] v1,
                             input logic [7:0] v2, input logic [7:0] v3, input bit both);
    logic [7:0] vals [4];
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    bus.start_load_input = 1'b1;
    bus.start_operate    = both;
    step();
    bus.start_load_input = 1'b0;
    bus.start_operate    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mmi_data = vals[i];
      chk({tag, "_done_early"}, 32'(bus.done_load_input), 32'd0);
      if (both) chk({tag, "_no_wreq"}, 32'(bus.weight_req), 32'd0);
      step();
    end
    bus.mmi_data = 8'd0;
    chk({tag, "_done_pulse"}, 32'(bus.done_load_input), 32'd1);
    step();
    chk({tag, "_done_clear"}, 32'(bus.done_load_input), 32'd0);
  endtask

  task automatic set_all_x(input logic [7:0] v);
    load_inputs("ldx", v, v, v, v, 1'b0);
    for (int a = 0; a < 9; a++) write_hidden(4'(a), v);
  endtask

  // One operation; inj_cyc>=0 fires illegal hidden write + load request in that cycle.
  task automatic run_op(input string tag, input logic [7:0] y_exp, input int inj_cyc);
    int cyc = 1;
    int nreq = 0;
    int nout = 0;
    int nload = 0;
    int done_cyc = -1;
    bus.start_operate = 1'b1;
    step();
    bus.start_operate = 1'b0;
    while (done_cyc < 0 && cyc < 200) begin
      if (bus.weight_req) nreq++;
      if (bus.done_load_input) nload++;
      if (bus.lc_oe_out) begin
        chk({tag, "_y"}, 32'(bus.lc_data_out), 32'(y_exp));
        nout++;
      end
      if (bus.done_operate) done_cyc = cyc;
      if (cyc == inj_cyc) begin
        bus.start_load_hidden = 1'b1;
        bus.hidden_address    = 4'd0;
        bus.lc_data_in        = 8'd0;
        bus.start_load_input  = 1'b1;
        bus.mmi_data          = 8'd0;
      end else begin
        bus.start_load_hidden = 1'b0;
        bus.start_load_input  = 1'b0;
      end
      step();
      cyc++;
    end
    chk({tag, "_nreq"}, 32'(nreq), 32'd39);
    chk({tag, "_nout"}, 32'(nout), 32'd9);
    chk({tag, "_latency"}, 32'(done_cyc), 32'd61);
    chk({tag, "_no_load_done"}, 32'(nload), 32'd0);
    chk({tag, "_done_clear"}, 32'(bus.done_operate), 32'd0);
  endtask

  initial begin
    int noe;
    int ndone;
    reset_n               = 1'b0;
    bus.start_load_hidden = 1'b0;
    bus.hidden_address    = '0;
    bus.lc_data_in        = '0;
    bus.start_load_input  = 1'b0;
    bus.mmi_data          = '0;
    bus.start_operate     = 1'b0;
    bus.weight_data       = '0;

    // Reset state
    step();
    step();
    chk("rst_done_load", 32'(bus.done_load_input), 32'd0);
    chk("rst_wreq",      32'(bus.weight_req),      32'd0);
    chk("rst_dout",      32'(bus.lc_data_out),     32'd0);
    chk("rst_oe",        32'(bus.lc_oe_out),       32'd0);
    chk("rst_done_op",   32'(bus.done_operate),    32'd0);
    reset_n = 1'b1;
    step();
    run_op("zero", 8'd0, -1);

    // Load 1..4, hidden still 0: y = 16*(1+2+3+4) >> 4 = 10
    load_inputs("load", 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    bus.weight_data = {4{8'd16}};
    run_op("load_prod", 8'd10, -1);

    // All x = 1, w = 16: y = 13*16 >> 4 = 13
    set_all_x(8'd1);
    run_op("prod", 8'd13, -1);

    // Saturation both ways
    set_all_x(8'd127);
    bus.weight_data = {4{8'd127}};
    run_op("sat_pos", 8'd127, -1);
    bus.weight_data = {4{8'h80}};
    run_op("sat_neg", 8'h80, -1);

    // Guards: out-of-range address, hidden write and load request during COMPUTE
    set_all_x(8'd1);
    bus.weight_data = {4{8'd16}};
    write_hidden(4'd9, 8'd0);
    run_op("guard_run", 8'd13, 5);
    run_op("guard_after", 8'd13, -1);

    // Simultaneous starts: load wins, x[0..3]=2 -> y = 16*(8+9) >> 4 = 17
    load_inputs("both", 8'd2, 8'd2, 8'd2, 8'd2, 1'b1);
    run_op("both_prod", 8'd17, -1);

    // Reset at COMPUTE cycle 20 aborts the operation
    set_all_x(8'd1);
    bus.start_operate = 1'b1;
    step();
    bus.start_operate = 1'b0;
    for (int i = 1; i < 20; i++) step();
    chk("abort_in_compute", 32'(bus.weight_req), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_wreq", 32'(bus.weight_req), 32'd0);
    noe   = 0;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.lc_oe_out) noe++;
      if (bus.done_operate) ndone++;
      step();
    end
    chk("abort_oe",   32'(noe),   32'd0);
    chk("abort_done", 32'(ndone), 32'd0);
    set_all_x(8'd1);
    run_op("post_abort", 8'd13, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
